// File: rtl/lcd_write_arbiter_if.sv
// Requester-side bus of the LCD write arbiter: two byte writers sharing one
// HD44780-style 4-bit port.
interface lcd_write_arbiter_if;
    // iReq[n] is requester n's valid; it must hold iDataN/iRSN stable while
    // high. oGrant[n] is a one-cycle acceptance pulse: the byte was latched at
    // the edge before the pulse. A still-high iReq after that is a new request.
    logic [1:0] iReq;
    logic [7:0] iData0;
    logic       iRS0;
    logic [7:0] iData1;
    logic       iRS1;
    logic [1:0] oGrant;

    modport master (
        output iReq, iData0, iRS0, iData1, iRS1,
        input  oGrant
    );

    modport slave (
        input  iReq, iData0, iRS0, iData1, iRS1,
        output oGrant
    );
endinterface

// File: rtl/lcd_write_arbiter.sv
// Round-robin arbiter for two LCD byte writers; each byte goes out as two
// E-strobed nibbles followed by a settle wait sized by the command.
module lcd_write_arbiter #(
    parameter int SETUP_CYC      = 2,
    parameter int EN_CYC         = 12,
    parameter int GAP_CYC        = 50,
    parameter int WAIT_CYC       = 2000,
    parameter int CLEAR_WAIT_CYC = 82000
) (
    input  logic                Clock,
    input  logic                Reset,
    lcd_write_arbiter_if.slave  req_bus,
    output logic                oBusy,
    output logic                oLCD_Enabled,
    output logic                oLCD_RegisterSelect,
    output logic                oLCD_ReadWrite,
    output logic [3:0]          oLCD_Data,
    output logic [2:0]          o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP_HI = 3'd1,
        S_EN_HI    = 3'd2,
        S_GAP      = 3'd3,
        S_SETUP_LO = 3'd4,
        S_EN_LO    = 3'd5,
        S_WAIT     = 3'd6
    } state_t;

    localparam logic [31:0] L_SETUP = 32'(SETUP_CYC - 1);
    localparam logic [31:0] L_EN    = 32'(EN_CYC - 1);
    localparam logic [31:0] L_GAP   = 32'(GAP_CYC - 1);
    localparam logic [31:0] L_WAIT  = 32'(WAIT_CYC - 1);
    localparam logic [31:0] L_CLEAR = 32'(CLEAR_WAIT_CYC - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_cnt;
    logic [31:0] w_cnt_next;
    logic [7:0]  r_byte;
    logic        r_rs;
    logic        r_last;
    logic        w_latch;
    logic        w_win;
    logic [1:0]  w_req;
    logic [7:0]  w_byte_next;
    logic        w_rs_next;
    logic        w_long;

    logic [1:0]  r_grant;
    logic        r_busy;
    logic        r_en;
    logic        r_rs_out;
    logic [3:0]  r_data;
    logic [1:0]  w_grant;
    logic        w_busy;
    logic        w_en;
    logic        w_rs_out;
    logic [3:0]  w_data;

    assign w_req = req_bus.iReq;

    // Tie goes to whoever was not served last; a lone request always wins.
    assign w_win = (w_req == 2'b11) ? ~r_last : w_req[1];

    assign w_byte_next = w_latch ? (w_win ? req_bus.iData1 : req_bus.iData0) : r_byte;
    assign w_rs_next   = w_latch ? (w_win ? req_bus.iRS1 : req_bus.iRS0) : r_rs;

    // Clear display / return home need the long settle time.
    assign w_long = ~r_rs && ((r_byte == 8'h01) || (r_byte == 8'h02) || (r_byte == 8'h03));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_byte   <= '0;
            r_rs     <= 1'b0;
            r_last   <= 1'b1;
            r_grant  <= 2'b00;
            r_busy   <= 1'b0;
            r_en     <= 1'b0;
            r_rs_out <= 1'b0;
            r_data   <= 4'h0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_byte   <= w_byte_next;
            r_rs     <= w_rs_next;
            if (w_latch) begin
                r_last <= w_win;
            end
            r_grant  <= w_grant;
            r_busy   <= w_busy;
            r_en     <= w_en;
            r_rs_out <= w_rs_out;
            r_data   <= w_data;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_latch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req != 2'b00) begin
                    w_latch      = 1'b1;
                    w_state_next = S_SETUP_HI;
                    w_cnt_next   = L_SETUP;
                end
            end
            S_SETUP_HI: begin
                if (r_cnt == '0) begin
                    w_state_next = S_EN_HI;
                    w_cnt_next   = L_EN;
                end else begin
                    w_cnt_next = r_cnt - 32'd1;
                end
            end
            S_EN_HI: begin
                if (r_cnt == '0) begin
                    w_state_next = S_GAP;
                    w_cnt_next   = L_GAP;
                end else begin
                    w_cnt_next = r_cnt - 32'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_next = S_SETUP_LO;
                    w_cnt_next   = L_SETUP;
                end else begin
                    w_cnt_next = r_cnt - 32'd1;
                end
            end
            S_SETUP_LO: begin
                if (r_cnt == '0) begin
                    w_state_next = S_EN_LO;
                    w_cnt_next   = L_EN;
                end else begin
                    w_cnt_next = r_cnt - 32'd1;
                end
            end
            S_EN_LO: begin
                if (r_cnt == '0) begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = w_long ? L_CLEAR : L_WAIT;
                end else begin
                    w_cnt_next = r_cnt - 32'd1;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 32'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the registered state; IDLE keeps the last nibble and RS on the bus.
    always_comb begin
        w_grant  = 2'b00;
        if (w_latch) begin
            w_grant = w_win ? 2'b10 : 2'b01;
        end
        w_busy   = (w_state_next != S_IDLE);
        w_en     = (w_state_next == S_EN_HI) || (w_state_next == S_EN_LO);
        w_rs_out = r_rs_out;
        w_data   = r_data;
        case (w_state_next)
            S_SETUP_HI, S_EN_HI, S_GAP: begin
                w_data   = w_byte_next[7:4];
                w_rs_out = w_rs_next;
            end
            S_SETUP_LO, S_EN_LO, S_WAIT: begin
                w_data   = w_byte_next[3:0];
                w_rs_out = w_rs_next;
            end
            default: ;
        endcase
    end

    assign req_bus.oGrant      = r_grant;
    assign oBusy               = r_busy;
    assign oLCD_Enabled        = r_en;
    assign oLCD_RegisterSelect = r_rs_out;
    assign oLCD_ReadWrite      = 1'b0;
    assign oLCD_Data           = r_data;
    assign o_dbg_state         = r_state;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: directed scenarios plus random traffic, every
// cycle compared with a transaction-level model of the LCD pin waveform.
module tb_lcd_write_arbiter;

    localparam int S  = 2;
    localparam int EN = 3;
    localparam int G  = 4;
    localparam int W  = 5;
    localparam int CW = 20;

    logic       Clock;
    logic       Reset;
    logic       oBusy;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_ReadWrite;
    logic [3:0] oLCD_Data;
    logic [2:0] dbg_state;

    lcd_write_arbiter_if bus ();

    lcd_write_arbiter #(
        .SETUP_CYC      (S),
        .EN_CYC         (EN),
        .GAP_CYC        (G),
        .WAIT_CYC       (W),
        .CLEAR_WAIT_CYC (CW)
    ) dut (
        .Clock               (Clock),
        .Reset               (Reset),
        .req_bus             (bus.slave),
        .oBusy               (oBusy),
        .oLCD_Enabled        (oLCD_Enabled),
        .oLCD_RegisterSelect (oLCD_RegisterSelect),
        .oLCD_ReadWrite      (oLCD_ReadWrite),
        .oLCD_Data           (oLCD_Data),
        .o_dbg_state         (dbg_state)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected word per cycle: {grant[1:0], busy, E, RS, data[3:0]}
    logic [8:0] exp_q[$];
    logic       mon_en      = 1'b0;
    logic       m_last      = 1'b1;
    logic       m_rs        = 1'b0;
    logic [3:0] m_data      = 4'h0;
    logic       m_prev_busy = 1'b0;
    logic       m_win;
    logic [8:0] m_word;

    // Whole byte waveform from the timing rules, one word per cycle after the grant.
    task automatic push_txn(input logic [1:0] g, input logic [7:0] b, input logic rs);
        int         waitc;
        int         len;
        logic       e;
        logic [3:0] nib;
        logic [1:0] gg;
        waitc = (!rs && b >= 8'h01 && b <= 8'h03) ? CW : W;
        len   = 2 * S + 2 * EN + G + waitc;
        for (int t = 0; t < len; t++) begin
            e   = ((t >= S) && (t < S + EN)) || ((t >= 2 * S + EN + G) && (t < 2 * S + 2 * EN + G));
            nib = (t < S + EN + G) ? b[7:4] : b[3:0];
            gg  = (t == 0) ? g : 2'b00;
            exp_q.push_back({gg, 1'b1, e, rs, nib});
        end
    endtask

    always @(posedge Clock) begin
        if (Reset) begin
            exp_q.delete();
            m_last      = 1'b1;
            m_rs        = 1'b0;
            m_data      = 4'h0;
            m_prev_busy = 1'b0;
        end else if (!m_prev_busy && bus.iReq != 2'b00) begin
            if (bus.iReq == 2'b11) m_win = (m_last == 1'b0);
            else                   m_win = bus.iReq[1];
            m_last = m_win;
            if (m_win) push_txn(2'b10, bus.iData1, bus.iRS1);
            else       push_txn(2'b01, bus.iData0, bus.iRS0);
        end
    end

    int         cyc = 0;
    int         busy_run = 0;
    int         last_busy_len = 0;
    int         e_run = 0;
    int         last_e_len = 0;
    int         n_epulse = 0;
    logic       e_prev = 1'b0;
    logic [3:0] e_nib_q[$];
    logic [1:0] grant_q[$];
    int         grant_cyc_q[$];

    always @(negedge Clock) begin
        if (mon_en) begin
            if (exp_q.size() != 0) m_word = exp_q.pop_front();
            else                   m_word = {2'b00, 1'b0, 1'b0, m_rs, m_data};
            m_rs        = m_word[4];
            m_data      = m_word[3:0];
            m_prev_busy = m_word[6];
            chk("cycle", 32'({bus.oGrant, oBusy, oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data}), 32'(m_word));
            chk("rw_low", 32'(oLCD_ReadWrite), 32'd0);
            if (oBusy) busy_run++;
            else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run      = 0;
            end
            if (oLCD_Enabled) e_run++;
            else if (e_run != 0) begin
                last_e_len = e_run;
                e_run      = 0;
            end
            if (oLCD_Enabled && !e_prev) begin
                n_epulse++;
                e_nib_q.push_back(oLCD_Data);
            end
            e_prev = oLCD_Enabled;
            if (bus.oGrant != 2'b00) begin
                grant_q.push_back(bus.oGrant);
                grant_cyc_q.push_back(cyc);
            end
            cyc++;
        end
    end

    task automatic drive(input logic [1:0] req, input logic [7:0] d0, input logic r0,
                         input logic [7:0] d1, input logic r1);
        bus.iReq   = req;
        bus.iData0 = d0;
        bus.iRS0   = r0;
        bus.iData1 = d1;
        bus.iRS1   = r1;
    endtask

    task automatic clear_logs();
        n_epulse = 0;
        e_nib_q.delete();
        grant_q.delete();
        grant_cyc_q.delete();
    endtask

    task automatic wait_grant(input int max, output logic [1:0] g);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        g    = 2'b00;
        while (!done && n < max) begin
            @(negedge Clock);
            #1;
            n++;
            if (bus.oGrant != 2'b00) begin
                done = 1'b1;
                g    = bus.oGrant;
            end
        end
        chk("grant_within_bound", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input int max);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        while (!done && n < max) begin
            @(negedge Clock);
            #1;
            n++;
            if (!oBusy) done = 1'b1;
        end
        chk("idle_within_bound", 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clock);
        #1;
        @(negedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    logic [1:0] g;
    logic [1:0] exp_g[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] t4_byte[6] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    logic       t4_rs[6]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int         t4_len[6]  = '{34, 19, 34, 34, 19, 19};

    initial begin
        Reset = 1'b1;
        drive(2'b00, 8'h00, 1'b0, 8'h00, 1'b0);
        repeat (3) @(posedge Clock);
        #1 mon_en = 1'b1;
        @(negedge Clock);
        #1;
        chk("rst_busy", 32'(oBusy), 32'd0);
        chk("rst_en", 32'(oLCD_Enabled), 32'd0);
        chk("rst_rs", 32'(oLCD_RegisterSelect), 32'd0);
        chk("rst_data", 32'(oLCD_Data), 32'd0);
        chk("rst_grant", 32'(bus.oGrant), 32'd0);
        Reset = 1'b0;

        // Single command byte 0x28
        clear_logs();
        drive(2'b01, 8'h28, 1'b0, 8'h00, 1'b0);
        wait_grant(5, g);
        drive(2'b00, 8'h28, 1'b0, 8'h00, 1'b0);
        chk("t1_grant", 32'(g), 32'd1);
        wait_idle(60);
        chk("t1_busy_len", 32'(last_busy_len), 32'd19);
        chk("t1_epulses", 32'(n_epulse), 32'd2);
        chk("t1_e_width", 32'(last_e_len), 32'd3);
        chk("t1_nib_hi", 32'(e_nib_q[0]), 32'h2);
        chk("t1_nib_lo", 32'(e_nib_q[1]), 32'h8);

        // Tie from reset: requester 0 first, requester 1 in the first IDLE cycle
        do_reset();
        clear_logs();
        drive(2'b11, 8'h41, 1'b1, 8'h42, 1'b1);
        wait_grant(5, g);
        chk("t2_first", 32'(g), 32'd1);
        chk("t2_rs", 32'(oLCD_RegisterSelect), 32'd1);
        chk("t2_hi_nib", 32'(oLCD_Data), 32'h4);
        bus.iReq = 2'b10;
        wait_grant(40, g);
        bus.iReq = 2'b00;
        chk("t2_second", 32'(g), 32'd2);
        chk("t2_gap", 32'(grant_cyc_q[1] - grant_cyc_q[0]), 32'd20);
        wait_idle(60);

        // Both held: strict alternation
        clear_logs();
        drive(2'b11, 8'h30, 1'b0, 8'h6a, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_grant(40, g);
            chk("t3_rr", 32'(g), 32'(exp_g[i]));
        end
        bus.iReq = 2'b00;
        wait_idle(60);

        // Long wait only for commands 0x01..0x03
        for (int i = 0; i < 6; i++) begin
            drive(2'b01, t4_byte[i], t4_rs[i], 8'h00, 1'b0);
            wait_grant(5, g);
            bus.iReq = 2'b00;
            wait_idle(80);
            chk("t4_busy_len", 32'(last_busy_len), 32'(t4_len[i]));
        end

        // Reset during the second EN_HI cycle with requester 1 pending
        clear_logs();
        drive(2'b01, 8'h5c, 1'b1, 8'h77, 1'b1);
        wait_grant(5, g);
        bus.iReq = 2'b00;
        repeat (3) @(negedge Clock);
        #1;
        chk("t5_e_before", 32'(oLCD_Enabled), 32'd1);
        Reset    = 1'b1;
        bus.iReq = 2'b10;
        @(negedge Clock);
        #1;
        chk("t5_e_after", 32'(oLCD_Enabled), 32'd0);
        chk("t5_busy_after", 32'(oBusy), 32'd0);
        chk("t5_no_grant", 32'(bus.oGrant), 32'd0);
        Reset = 1'b0;
        wait_grant(3, g);
        bus.iReq = 2'b00;
        chk("t5_grant", 32'(g), 32'd2);
        wait_idle(60);
        chk("t5_epulses", 32'(n_epulse), 32'd3);

        // Short request pulse while busy is ignored
        clear_logs();
        drive(2'b01, 8'h55, 1'b1, 8'h99, 1'b0);
        wait_grant(5, g);
        bus.iReq = 2'b00;
        repeat (3) @(negedge Clock);
        #1 bus.iReq = 2'b10;
        repeat (4) @(negedge Clock);
        #1 bus.iReq = 2'b00;
        wait_idle(60);
        repeat (5) @(negedge Clock);
        #1;
        chk("t6_grants", 32'(grant_q.size()), 32'd1);
        chk("t6_epulses", 32'(n_epulse), 32'd2);

        // Random traffic against the model
        for (int i = 0; i < 40; i++) begin
            logic [1:0] rq;
            logic [7:0] a;
            logic [7:0] b;
            int         hold;
            rq = 2'($urandom_range(1, 3));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(1, 3));
            drive(rq, a, 1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)));
            hold = $urandom_range(1, 40);
            repeat (hold) @(negedge Clock);
            #1;
            drive(2'b00, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            wait_idle(100);
            repeat ($urandom_range(0, 3)) @(negedge Clock);
            #1;
        end

        repeat (3) @(negedge Clock);
        #1;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
